hazard_unit: RTL and testbench

- Stall/flush scheduler for the MIPS 5-stage pipeline. Sits beside the instruction-decode controller.
- Keeps a small scoreboard of in-flight register writes in EXE/MEM/WB. Detects RAW hazards for the instruction in ID and inserts bubbles (no forwarding path exists).
- Squashes wrong-path instructions on jumps (resolved in ID) and taken branches (resolved in EXE).
- Drives the per-stage enable and reset signals of the pipeline registers and keeps saturating performance counters.

---
 rtl/hazard_unit_pkg.sv | 37 +++
 rtl/hazard_sb_entry_cmp.sv | 19 +
 rtl/hazard_unit.sv | 173 +++++++++++++++++
 tb/tb_hazard_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry layout,
// scoreboard stage indices and the per-cycle scheduling decision.
package hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] addr;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = sb_entry_t'{valid: 1'b0, addr: REG_ZERO};

    localparam int STAGE_EXE  = 0;
    localparam int STAGE_MEM  = 1;
    localparam int STAGE_WB   = 2;
    localparam int NUM_STAGES = 3;

    typedef enum logic [2:0] {
        SCHED_RESET,
        SCHED_HOLD,
        SCHED_BRANCH,
        SCHED_STALL,
        SCHED_JUMP,
        SCHED_RUN
    } sched_e;

    // $0 is hard-wired, so a write to it never creates a pending producer.
    function automatic sb_entry_t make_entry(input logic wen, input logic [REG_W-1:0] addr);
        sb_entry_t e;
        e.valid = wen && (addr != REG_ZERO);
        e.addr  = addr;
        return e;
    endfunction

endpackage

// File: rtl/hazard_sb_entry_cmp.sv
// Compares one scoreboard entry against one source operand of the ID instruction.
module hazard_sb_entry_cmp
    import hazard_unit_pkg::*;
(
    input  logic             cmp_en,
    input  sb_entry_t        entry,
    input  logic             src_used,
    input  logic [REG_W-1:0] src_addr,
    output logic             hit
);

    assign hit = cmp_en
              && src_used
              && (src_addr != REG_ZERO)
              && entry.valid
              && (entry.addr != REG_ZERO)
              && (entry.addr == src_addr);

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: tracks in-flight register
// writes, inserts RAW bubbles, squashes wrong-path fetches and counts events.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter bit WB_SAME_CYCLE = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_en,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wb_wen,
    input  logic [REG_W-1:0] id_wb_addr,
    input  logic             id_jump,
    input  logic             exe_branch_taken,
    output logic             pc_en,
    output logic             if_en,
    output logic             if_rst,
    output logic             id_en,
    output logic             id_rst,
    output logic             exe_en,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t             sb_q [NUM_STAGES];
    sb_entry_t             sb_d [NUM_STAGES];
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic [NUM_STAGES-1:0] stage_cmp_en;
    logic [NUM_STAGES-1:0] rs_hit;
    logic [NUM_STAGES-1:0] rt_hit;
    logic                  hz;
    logic                  sb_advance;
    logic                  sb_load_id;
    sched_e                sched;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // With negedge regfile writes the WB producer is already visible to ID.
    always_comb begin
        stage_cmp_en           = '1;
        stage_cmp_en[STAGE_WB] = !WB_SAME_CYCLE;
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_cmp
        hazard_sb_entry_cmp u_rs_cmp (
            .cmp_en   (stage_cmp_en[s]),
            .entry    (sb_q[s]),
            .src_used (id_rs_used),
            .src_addr (id_rs),
            .hit      (rs_hit[s])
        );

        hazard_sb_entry_cmp u_rt_cmp (
            .cmp_en   (stage_cmp_en[s]),
            .entry    (sb_q[s]),
            .src_used (id_rt_used),
            .src_addr (id_rt),
            .hit      (rt_hit[s])
        );
    end

    assign hz = (|rs_hit) || (|rt_hit);

    always_comb begin
        if (rst) begin
            sched = SCHED_RESET;
        end else if (!cpu_en) begin
            sched = SCHED_HOLD;
        end else if (exe_branch_taken) begin
            sched = SCHED_BRANCH;
        end else if (hz) begin
            sched = SCHED_STALL;
        end else if (id_jump) begin
            sched = SCHED_JUMP;
        end else begin
            sched = SCHED_RUN;
        end
    end

    always_comb begin
        pc_en  = 1'b0;
        if_en  = 1'b0;
        if_rst = 1'b0;
        id_en  = 1'b0;
        id_rst = 1'b0;
        exe_en = 1'b0;
        stall  = 1'b0;
        case (sched)
            SCHED_RESET: begin
                if_rst = 1'b1;
                id_rst = 1'b1;
            end
            SCHED_HOLD: begin
            end
            SCHED_BRANCH: begin
                pc_en  = 1'b1;
                if_en  = 1'b1;
                id_en  = 1'b1;
                exe_en = 1'b1;
                if_rst = 1'b1;
                id_rst = 1'b1;
            end
            // Freeze PC and IF/ID; the ID instruction is re-decoded next cycle.
            SCHED_STALL: begin
                id_en  = 1'b1;
                id_rst = 1'b1;
                exe_en = 1'b1;
                stall  = 1'b1;
            end
            SCHED_JUMP: begin
                pc_en  = 1'b1;
                if_en  = 1'b1;
                id_en  = 1'b1;
                exe_en = 1'b1;
                if_rst = 1'b1;
            end
            default: begin
                pc_en  = 1'b1;
                if_en  = 1'b1;
                id_en  = 1'b1;
                exe_en = 1'b1;
            end
        endcase
    end

    assign sb_advance = (sched == SCHED_BRANCH) || (sched == SCHED_STALL)
                     || (sched == SCHED_JUMP)   || (sched == SCHED_RUN);
    assign sb_load_id = (sched == SCHED_JUMP) || (sched == SCHED_RUN);

    always_comb begin
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (sb_advance) begin
            sb_d[STAGE_WB]  = sb_q[STAGE_MEM];
            sb_d[STAGE_MEM] = sb_q[STAGE_EXE];
            sb_d[STAGE_EXE] = sb_load_id ? make_entry(id_wb_wen, id_wb_addr) : SB_EMPTY;
        end
        if (sched == SCHED_STALL) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if ((sched == SCHED_BRANCH) || (sched == SCHED_JUMP)) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                sb_q[i] <= SB_EMPTY;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed table-driven bench for hazard_unit: default build, WB-compare build
// and a 2-bit counter build for saturation, all driven from shared inputs.
module tb_hazard_unit;

    localparam logic [6:0] O_RST   = 7'b0010100;
    localparam logic [6:0] O_HOLD  = 7'b0000000;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_STALL = 7'b0001111;
    localparam logic [6:0] O_JUMP  = 7'b1111010;
    localparam logic [6:0] O_RUN   = 7'b1101010;

    typedef struct {
        bit       rst;
        bit       en;
        bit [4:0] rs;
        bit       rs_u;
        bit [4:0] rt;
        bit       rt_u;
        bit       wen;
        bit [4:0] wa;
        bit       jmp;
        bit       br;
        bit [6:0] exp_out;
        int       exp_s;
        int       exp_f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_en;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wb_wen;
    logic [4:0] id_wb_addr;
    logic       id_jump;
    logic       exe_branch_taken;

    logic [2:0]  pc_en_w, if_en_w, if_rst_w, id_en_w, id_rst_w, exe_en_w, stall_w;
    logic [15:0] stall_cnt_0, flush_cnt_0, stall_cnt_1, flush_cnt_1;
    logic [1:0]  stall_cnt_2, flush_cnt_2;

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_unit #(.WB_SAME_CYCLE(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wb_wen(id_wb_wen), .id_wb_addr(id_wb_addr), .id_jump(id_jump),
        .exe_branch_taken(exe_branch_taken),
        .pc_en(pc_en_w[0]), .if_en(if_en_w[0]), .if_rst(if_rst_w[0]), .id_en(id_en_w[0]),
        .id_rst(id_rst_w[0]), .exe_en(exe_en_w[0]), .stall(stall_w[0]),
        .stall_cnt(stall_cnt_0), .flush_cnt(flush_cnt_0)
    );

    hazard_unit #(.WB_SAME_CYCLE(1'b0), .CNT_W(16)) dut_wb (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wb_wen(id_wb_wen), .id_wb_addr(id_wb_addr), .id_jump(id_jump),
        .exe_branch_taken(exe_branch_taken),
        .pc_en(pc_en_w[1]), .if_en(if_en_w[1]), .if_rst(if_rst_w[1]), .id_en(id_en_w[1]),
        .id_rst(id_rst_w[1]), .exe_en(exe_en_w[1]), .stall(stall_w[1]),
        .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
    );

    hazard_unit #(.WB_SAME_CYCLE(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wb_wen(id_wb_wen), .id_wb_addr(id_wb_addr), .id_jump(id_jump),
        .exe_branch_taken(exe_branch_taken),
        .pc_en(pc_en_w[2]), .if_en(if_en_w[2]), .if_rst(if_rst_w[2]), .id_en(id_en_w[2]),
        .id_rst(id_rst_w[2]), .exe_en(exe_en_w[2]), .stall(stall_w[2]),
        .stall_cnt(stall_cnt_2), .flush_cnt(flush_cnt_2)
    );

    // Argument order: rst, en, rs, rs_used, rt, rt_used, wen, wa, jump, branch, outputs, stall_cnt, flush_cnt
    function automatic vec_t v(input bit r, input bit e, input int rs, input bit rsu,
                               input int rt, input bit rtu, input bit wen, input int wa,
                               input bit j, input bit b, input bit [6:0] o,
                               input int s, input int f);
        vec_t t;
        t.rst = r;  t.en = e;
        t.rs = rs[4:0]; t.rs_u = rsu;
        t.rt = rt[4:0]; t.rt_u = rtu;
        t.wen = wen; t.wa = wa[4:0];
        t.jmp = j;  t.br = b;
        t.exp_out = o; t.exp_s = s; t.exp_f = f;
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        rst              = t.rst;
        cpu_en           = t.en;
        id_rs            = t.rs;
        id_rs_used       = t.rs_u;
        id_rt            = t.rt;
        id_rt_used       = t.rt_u;
        id_wb_wen        = t.wen;
        id_wb_addr       = t.wa;
        id_jump          = t.jmp;
        exe_branch_taken = t.br;
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input vec_t t);
        logic [6:0]  got_out;
        logic [15:0] got_s;
        logic [15:0] got_f;
        got_out = {pc_en_w[sel], if_en_w[sel], if_rst_w[sel], id_en_w[sel],
                   id_rst_w[sel], exe_en_w[sel], stall_w[sel]};
        case (sel)
            0:       begin got_s = stall_cnt_0; got_f = flush_cnt_0; end
            1:       begin got_s = stall_cnt_1; got_f = flush_cnt_1; end
            default: begin got_s = {14'd0, stall_cnt_2}; got_f = {14'd0, flush_cnt_2}; end
        endcase
        checks++;
        if (got_out !== t.exp_out) begin
            errors++;
            $display("[TB] FAIL %s[%0d] ctl {pc,if,ifr,id,idr,exe,stall} got %b want %b",
                     name, idx, got_out, t.exp_out);
        end
        checks++;
        if (got_s !== 16'(t.exp_s)) begin
            errors++;
            $display("[TB] FAIL %s[%0d] stall_cnt got %0d want %0d", name, idx, got_s, t.exp_s);
        end
        checks++;
        if (got_f !== 16'(t.exp_f)) begin
            errors++;
            $display("[TB] FAIL %s[%0d] flush_cnt got %0d want %0d", name, idx, got_f, t.exp_f);
        end
    endtask

    task automatic runTable(input int which, input string name);
        sel = which;
        applyStimulus(v(1,1, 0,0, 0,0, 0,0, 0,0, O_RST, 0,0));
        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(name, i, tbl[i]);
            @(posedge clk); #1;
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0;
        id_rt_used = 1'b0; id_wb_wen = 1'b0; id_wb_addr = '0; id_jump = 1'b0;
        exe_branch_taken = 1'b0;
        @(posedge clk); #1;

        // Default build: back-to-back, gap, $0, jump, branch, debug hold, jump-vs-stall, reset.
        tbl.push_back(v(1,1,  0,0,  0,0, 0, 0, 0,0, O_RST,   0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 1, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  1,1,  3,1, 1, 2, 0,0, O_STALL, 0,0));
        tbl.push_back(v(0,1,  1,1,  3,1, 1, 2, 0,0, O_STALL, 1,0));
        tbl.push_back(v(0,1,  1,1,  3,1, 1, 2, 0,0, O_RUN,   2,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 4, 0,0, O_RUN,   2,0));
        tbl.push_back(v(0,1,  5,1,  0,0, 0, 0, 0,0, O_RUN,   2,0));
        tbl.push_back(v(0,1,  4,1,  0,0, 1, 6, 0,0, O_STALL, 2,0));
        tbl.push_back(v(0,1,  4,1,  0,0, 1, 6, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,1,  0,1, 0, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  6,1, 0, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 1,0, O_JUMP,  3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,0, O_RUN,   3,1));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 7, 0,0, O_RUN,   3,1));
        tbl.push_back(v(0,1,  7,1,  0,0, 1, 8, 0,1, O_BR,    3,1));
        tbl.push_back(v(0,1,  8,1,  0,0, 0, 0, 0,0, O_RUN,   3,2));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 9, 0,0, O_RUN,   3,2));
        tbl.push_back(v(0,1,  9,1,  0,0, 0, 0, 0,0, O_STALL, 3,2));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(0,0, 9,1, 0,0, 0, 0, 0,0, O_HOLD, 4,2));
        end
        tbl.push_back(v(0,1,  9,1,  0,0, 0, 0, 0,0, O_STALL, 4,2));
        tbl.push_back(v(0,1,  9,1,  0,0, 0, 0, 0,0, O_RUN,   5,2));
        tbl.push_back(v(0,1,  0,0,  0,0, 1,10, 0,0, O_RUN,   5,2));
        tbl.push_back(v(0,1, 10,1,  0,0, 0, 0, 1,0, O_STALL, 5,2));
        tbl.push_back(v(0,1, 10,1,  0,0, 0, 0, 1,0, O_STALL, 6,2));
        tbl.push_back(v(0,1, 10,1,  0,0, 0, 0, 1,0, O_JUMP,  7,2));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,0, O_RUN,   7,3));
        tbl.push_back(v(0,1,  0,0,  0,0, 1,11, 0,0, O_RUN,   7,3));
        tbl.push_back(v(0,1, 11,1,  0,0, 0, 0, 0,0, O_STALL, 7,3));
        tbl.push_back(v(1,1, 11,1,  0,0, 0, 0, 0,0, O_RST,   8,3));
        tbl.push_back(v(0,1, 11,1,  0,0, 0, 0, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1,12, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1, 12,0,  0,0, 0, 0, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  0,0, 12,1, 0, 0, 0,0, O_STALL, 0,0));
        tbl.push_back(v(0,1,  0,0, 12,1, 0, 0, 0,0, O_RUN,   1,0));
        tbl.push_back(v(0,0,  0,0,  0,0, 0, 0, 0,1, O_HOLD,  1,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,1, O_BR,    1,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,0, O_RUN,   1,1));
        runTable(0, "wbsame");

        // WB entry compared: one extra stall cycle in each case.
        tbl.push_back(v(1,1,  0,0,  0,0, 0, 0, 0,0, O_RST,   0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 1, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_STALL, 0,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_STALL, 1,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_STALL, 2,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 2, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_STALL, 3,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_STALL, 4,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_RUN,   5,0));
        runTable(1, "wbcmp");

        // 2-bit counters: stall and flush counts pin at 3, reset mid-stall clears.
        tbl.push_back(v(1,1,  0,0,  0,0, 0, 0, 0,0, O_RST,   0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 1, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_STALL, 0,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_STALL, 1,0));
        tbl.push_back(v(0,1,  1,1,  0,0, 0, 0, 0,0, O_RUN,   2,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 2, 0,0, O_RUN,   2,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_STALL, 2,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_STALL, 3,0));
        tbl.push_back(v(0,1,  2,1,  0,0, 0, 0, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 1, 3, 0,0, O_RUN,   3,0));
        tbl.push_back(v(0,1,  3,1,  0,0, 0, 0, 0,0, O_STALL, 3,0));
        tbl.push_back(v(1,1,  3,1,  0,0, 0, 0, 0,0, O_RST,   3,0));
        tbl.push_back(v(0,1,  3,1,  0,0, 0, 0, 0,0, O_RUN,   0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 1,0, O_JUMP,  0,0));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 1,0, O_JUMP,  0,1));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 1,0, O_JUMP,  0,2));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 1,0, O_JUMP,  0,3));
        tbl.push_back(v(0,1,  0,0,  0,0, 0, 0, 0,0, O_RUN,   0,3));
        runTable(2, "sat");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
